// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
//   Oversampled UART receiver with a show-ahead receive FIFO.
//   The receiver takes three samples around mid-bit and uses a majority vote.
//   It handles an optional parity bit, 1 or 2 stop bits, and break detection.
//   Every received word is stored as {frm_err, par_err, data}.
//
// Ports
//   clk, rst                  system clock; asynchronous active-low reset
//   rx_in                     asynchronous serial line, idle high
//   prescale                  oversampling ratio P (even, 8..32)
//   par_en, par_type, stop2   frame format; latched when a start edge is seen
//   rd_en                     pop the FIFO head (ignored when the FIFO is empty)
//   rd_data, rd_par_err,
//   rd_frm_err                FIFO head word (show-ahead)
//   rx_empty, rx_full,
//   fifo_level                FIFO occupancy
//   ovr_err                   1-cycle pulse: completed word dropped, FIFO full
//   brk_det                   1-cycle pulse: break frame received
//   busy                      receiver FSM is not idle
//   state_dbg                 raw FSM state, for debug and checkers
//
// Handshake: a word is readable whenever rx_empty is 0.
// Asserting rd_en in such a cycle consumes rd_data, and the next entry
// becomes visible on the following cycle.
module uart_rx_fifo #(
  parameter int DATA_WIDTH  = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         rx_in,
  input  logic [5:0]                   prescale,
  input  logic                         par_en,
  input  logic                         par_type,
  input  logic                         stop2,
  input  logic                         rd_en,
  output logic [DATA_WIDTH-1:0]        rd_data,
  output logic                         rd_par_err,
  output logic                         rd_frm_err,
  output logic                         rx_empty,
  output logic                         rx_full,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
  output logic                         ovr_err,
  output logic                         brk_det,
  output logic                         busy,
  output logic [2:0]                   state_dbg
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int EW = DATA_WIDTH + 2;
  localparam int BW = $clog2(DATA_WIDTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  // Input synchroniser. The flops reset to the idle line level.
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync_q <= '1;
    else      sync_q <= {sync_q[SYNC_STAGES-2:0], rx_in};
  end
  assign rx_s = sync_q[SYNC_STAGES-1];

  // Receiver FSM and bit timing
  state_t                state;
  logic                  rx_prev;
  logic [5:0]            edge_cnt;
  logic [5:0]            p_q;
  logic                  par_en_q, par_type_q, stop2_q;
  logic                  s0, s1, bit_q;
  logic [DATA_WIDTH-1:0] shreg;
  logic [BW-1:0]         bit_idx;
  logic                  stop_idx;
  logic                  par_err_q, par_bit_q, frm_q;

  logic [5:0] half;
  logic       at_s0, at_s1, at_dec, at_end, maj, frm_next;
  logic       push, push_brk;
  logic [EW-1:0] push_word;

  assign half     = {1'b0, p_q[5:1]};
  assign at_s0    = (edge_cnt == half - 6'd1);
  assign at_s1    = (edge_cnt == half);
  assign at_dec   = (edge_cnt == half + 6'd1);
  assign at_end   = (edge_cnt == p_q - 6'd1);
  assign maj      = (s0 & s1) | (s0 & rx_s) | (s1 & rx_s);
  assign frm_next = frm_q | ~bit_q;

  assign push      = (state == S_STOP) && at_end && (!stop2_q || stop_idx);
  assign push_word = {frm_next, par_err_q, shreg};
  // A break is a frame that is low throughout, including the parity bit when parity is present.
  assign push_brk  = (shreg == '0) && frm_next && (!par_en_q || !par_bit_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      rx_prev    <= 1'b1;
      edge_cnt   <= '0;
      p_q        <= '0;
      par_en_q   <= 1'b0;
      par_type_q <= 1'b0;
      stop2_q    <= 1'b0;
      s0         <= 1'b1;
      s1         <= 1'b1;
      bit_q      <= 1'b1;
      shreg      <= '0;
      bit_idx    <= '0;
      stop_idx   <= 1'b0;
      par_err_q  <= 1'b0;
      par_bit_q  <= 1'b0;
      frm_q      <= 1'b0;
    end else begin
      rx_prev <= rx_s;
      case (state)
        S_IDLE: begin
          if (rx_prev && !rx_s) begin
            // The edge cycle counts as tick 0 of the start bit, so the
            // counter enters START at 1 and stays aligned to the line.
            state      <= S_START;
            edge_cnt   <= 6'd1;
            p_q        <= prescale;
            par_en_q   <= par_en;
            par_type_q <= par_type;
            stop2_q    <= stop2;
            bit_idx    <= '0;
            stop_idx   <= 1'b0;
            par_err_q  <= 1'b0;
            par_bit_q  <= 1'b0;
            frm_q      <= 1'b0;
          end
        end
        default: begin
          edge_cnt <= at_end ? 6'd0 : edge_cnt + 6'd1;
          if (at_s0)  s0    <= rx_s;
          if (at_s1)  s1    <= rx_s;
          if (at_dec) bit_q <= maj;
          case (state)
            S_START: begin
              if (at_dec && maj) state <= S_IDLE;   // glitch, not a start bit
              else if (at_end)   state <= S_DATA;
            end
            S_DATA: begin
              if (at_end) begin
                shreg   <= {bit_q, shreg[DATA_WIDTH-1:1]};
                bit_idx <= bit_idx + 1'b1;
                if (bit_idx == BW'(DATA_WIDTH - 1))
                  state <= par_en_q ? S_PARITY : S_STOP;
              end
            end
            S_PARITY: begin
              if (at_end) begin
                par_bit_q <= bit_q;
                par_err_q <= ((^shreg) ^ bit_q) != par_type_q;
                state     <= S_STOP;
              end
            end
            S_STOP: begin
              if (at_end) begin
                frm_q <= frm_next;
                if (stop2_q && !stop_idx) stop_idx <= 1'b1;
                else                      state    <= S_IDLE;
              end
            end
            default: state <= S_IDLE;
          endcase
        end
      endcase
    end
  end

  assign busy      = (state != S_IDLE);
  assign state_dbg = state;

  // Receive FIFO. The pointers carry one extra wrap bit.
  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [LW-1:0] wr_ptr, rd_ptr;
  logic          pop, wr_ok;

  assign fifo_level = wr_ptr - rd_ptr;
  assign rx_empty   = (fifo_level == '0);
  assign rx_full    = (fifo_level == LW'(FIFO_DEPTH));
  assign pop        = rd_en && !rx_empty;
  // When the FIFO is full, a same-cycle pop frees the slot that is being written.
  assign wr_ok      = push && (!rx_full || pop);
  assign ovr_err    = push && rx_full && !pop;
  assign brk_det    = push && push_brk;
  assign {rd_frm_err, rd_par_err, rd_data} = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wr_ok) begin
        mem[wr_ptr[AW-1:0]] <= push_word;
        wr_ptr              <= wr_ptr + LW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + LW'(1);
    end
  end

endmodule
